// File: rtl/packet_chk.sv
// packet_chk: checks framed GT receive traffic (header, sequence, control, payload, checksum)
// and keeps saturating statistics. Define PKT_CHK_SEQ_EN to enable sequence-number checking.
module packet_chk #(
  parameter logic [7:0]  K_CHAR  = 8'hBC,
  parameter logic [15:0] MAX_LEN = 16'd1024,
  parameter int          CNT_W   = 32
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [31:0]      gt_rx_data,
  input  logic [3:0]       gt_rx_ctrl,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [7:0]       pkt_type_o,
  output logic [15:0]      pkt_len_o,
  output logic [CNT_W-1:0] packet_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] csum_err_cnt_o,
  output logic [CNT_W-1:0] seq_err_cnt_o,
  output logic [CNT_W-1:0] len_err_cnt_o,
  output logic [CNT_W-1:0] trunc_err_cnt_o,
  output logic             seq_locked_o
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_HEADER = 3'd1,
    SEQ_NUM     = 3'd2,
    CTRL        = 3'd3,
    DATA        = 3'd4,
    CHECK       = 3'd5
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_csum;
  logic [15:0] r_len;
  logic [7:0]  r_type;
  logic [15:0] r_word_cnt;

  logic        r_pkt_done;
  logic        r_pkt_ok;
  logic [7:0]  r_pkt_type;
  logic [15:0] r_pkt_len;
  logic [CNT_W-1:0] r_packet_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_csum_err_cnt;
  logic [CNT_W-1:0] r_len_err_cnt;
  logic [CNT_W-1:0] r_trunc_err_cnt;

  logic        w_hdr;
  logic [15:0] w_len_in;
  logic        w_len_ok;
  logic        w_term;
  logic        w_len_err;
  logic        w_trunc_err;
  logic        w_csum_err;
  logic        w_seq_err;
  logic        w_any_err;
  logic        w_clr_csum;
  logic        w_acc;
  logic [15:0] w_term_len;
  logic [7:0]  w_term_type;
  logic        w_unused;

  assign w_hdr    = gt_rx_ctrl[0] && (gt_rx_data[7:0] == K_CHAR);
  assign w_len_in = gt_rx_data[31:16];
  assign w_len_ok = (w_len_in >= 16'd1) && (w_len_in <= MAX_LEN);
  assign w_unused = ^gt_rx_ctrl[3:1];

  // FSM state register
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and termination decode
  always_comb begin
    w_state_nxt = r_state;
    w_term      = 1'b0;
    w_len_err   = 1'b0;
    w_trunc_err = 1'b0;
    w_csum_err  = 1'b0;
    w_clr_csum  = 1'b0;
    w_acc       = 1'b0;
    w_term_len  = r_len;
    w_term_type = r_type;
    case (r_state)
      IDLE: begin
        w_state_nxt = WAIT_HEADER;
      end
      WAIT_HEADER: begin
        w_clr_csum = 1'b1;
        if (w_hdr) begin
          w_state_nxt = SEQ_NUM;
        end else begin
          w_state_nxt = WAIT_HEADER;
        end
      end
      SEQ_NUM: begin
        w_state_nxt = CTRL;
      end
      CTRL: begin
        w_term_len  = w_len_in;
        w_term_type = gt_rx_data[7:0];
        if (w_len_ok) begin
          w_state_nxt = DATA;
        end else begin
          w_term      = 1'b1;
          w_len_err   = 1'b1;
          w_state_nxt = WAIT_HEADER;
        end
      end
      DATA: begin
        // A header inside the payload starts a new frame; the header word is reused.
        if (w_hdr) begin
          w_term      = 1'b1;
          w_trunc_err = 1'b1;
          w_clr_csum  = 1'b1;
          w_state_nxt = SEQ_NUM;
        end else begin
          w_acc = 1'b1;
          if (r_word_cnt == (r_len - 16'd1)) begin
            w_state_nxt = CHECK;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      CHECK: begin
        w_term = 1'b1;
        if (w_hdr) begin
          w_trunc_err = 1'b1;
          w_clr_csum  = 1'b1;
          w_state_nxt = SEQ_NUM;
        end else begin
          w_csum_err  = (gt_rx_data != r_csum);
          w_state_nxt = WAIT_HEADER;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Checksum, captured length/type and payload word counter
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_csum     <= 32'd0;
      r_len      <= 16'd0;
      r_type     <= 8'd0;
      r_word_cnt <= 16'd0;
    end else begin
      if (w_clr_csum) begin
        r_csum <= 32'd0;
      end else if (w_acc) begin
        r_csum <= r_csum + gt_rx_data;
      end
      if (r_state == CTRL) begin
        r_len      <= w_len_in;
        r_type     <= gt_rx_data[7:0];
        r_word_cnt <= 16'd0;
      end else if (w_acc) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

`ifdef PKT_CHK_SEQ_EN
  logic [31:0]      r_seq_ref;
  logic             r_seq_locked;
  logic             r_pkt_seq_err;
  logic [CNT_W-1:0] r_seq_err_cnt;

  // Sequence reference tracking; the result is held until the packet terminates
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_seq_ref     <= 32'd0;
      r_seq_locked  <= 1'b0;
      r_pkt_seq_err <= 1'b0;
      r_seq_err_cnt <= '0;
    end else begin
      if (r_state == SEQ_NUM) begin
        r_seq_ref     <= gt_rx_data;
        r_pkt_seq_err <= r_seq_locked && (gt_rx_data != (r_seq_ref + 32'd1));
      end
      if (clr) begin
        r_seq_locked  <= 1'b0;
        r_seq_err_cnt <= '0;
      end else begin
        if (r_state == SEQ_NUM) begin
          r_seq_locked <= 1'b1;
        end
        r_seq_err_cnt <= sat_inc(r_seq_err_cnt, w_seq_err);
      end
    end
  end

  assign w_seq_err     = w_term && r_pkt_seq_err;
  assign seq_locked_o  = r_seq_locked;
  assign seq_err_cnt_o = r_seq_err_cnt;
`else
  assign w_seq_err     = 1'b0;
  assign seq_locked_o  = 1'b0;
  assign seq_err_cnt_o = '0;
`endif

  assign w_any_err = w_len_err || w_trunc_err || w_csum_err || w_seq_err;

  // Termination report, held until the next termination
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_pkt_done <= 1'b0;
      r_pkt_ok   <= 1'b0;
      r_pkt_type <= 8'd0;
      r_pkt_len  <= 16'd0;
    end else begin
      r_pkt_done <= w_term;
      if (w_term) begin
        r_pkt_ok   <= !w_any_err;
        r_pkt_type <= w_term_type;
        r_pkt_len  <= w_term_len;
      end
    end
  end

  // Statistics counters; clr wins over a coincident increment
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_packet_cnt    <= '0;
      r_err_cnt       <= '0;
      r_csum_err_cnt  <= '0;
      r_len_err_cnt   <= '0;
      r_trunc_err_cnt <= '0;
    end else if (clr) begin
      r_packet_cnt    <= '0;
      r_err_cnt       <= '0;
      r_csum_err_cnt  <= '0;
      r_len_err_cnt   <= '0;
      r_trunc_err_cnt <= '0;
    end else begin
      r_packet_cnt    <= sat_inc(r_packet_cnt, w_term);
      r_err_cnt       <= sat_inc(r_err_cnt, w_term && w_any_err);
      r_csum_err_cnt  <= sat_inc(r_csum_err_cnt, w_csum_err);
      r_len_err_cnt   <= sat_inc(r_len_err_cnt, w_len_err);
      r_trunc_err_cnt <= sat_inc(r_trunc_err_cnt, w_trunc_err);
    end
  end

  assign pkt_done        = r_pkt_done;
  assign pkt_ok          = r_pkt_ok;
  assign pkt_type_o      = r_pkt_type;
  assign pkt_len_o       = r_pkt_len;
  assign packet_cnt_o    = r_packet_cnt;
  assign err_cnt_o       = r_err_cnt;
  assign csum_err_cnt_o  = r_csum_err_cnt;
  assign len_err_cnt_o   = r_len_err_cnt;
  assign trunc_err_cnt_o = r_trunc_err_cnt;

endmodule

// File: tb/tb_packet_chk.sv
// tb_packet_chk: directed frames with hand-computed expectations for packet_chk;
// sequence expectations follow PKT_CHK_SEQ_EN.
module tb_packet_chk;

`ifdef PKT_CHK_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        rx_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        clr    = 1'b0;
  logic [31:0] gt_rx_data = 32'd0;
  logic [3:0]  gt_rx_ctrl = 4'd0;
  logic        pkt_done, pkt_ok, seq_locked_o;
  logic [7:0]  pkt_type_o;
  logic [15:0] pkt_len_o;
  logic [31:0] packet_cnt_o, err_cnt_o, csum_err_cnt_o, seq_err_cnt_o, len_err_cnt_o, trunc_err_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int ok_cnt   = 0;

  packet_chk dut (
    .rx_clk(rx_clk), .rst(rst), .clr(clr),
    .gt_rx_data(gt_rx_data), .gt_rx_ctrl(gt_rx_ctrl),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_type_o(pkt_type_o), .pkt_len_o(pkt_len_o),
    .packet_cnt_o(packet_cnt_o), .err_cnt_o(err_cnt_o), .csum_err_cnt_o(csum_err_cnt_o),
    .seq_err_cnt_o(seq_err_cnt_o), .len_err_cnt_o(len_err_cnt_o),
    .trunc_err_cnt_o(trunc_err_cnt_o), .seq_locked_o(seq_locked_o)
  );

  always #5 rx_clk = ~rx_clk;

  always @(negedge rx_clk) begin
    if (pkt_done === 1'b1) begin
      done_cnt++;
      if (pkt_ok === 1'b1) ok_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word; returns 1 time unit after the edge that samples it
  task automatic drive_word(input logic [31:0] d, input logic [3:0] c);
    gt_rx_data = d;
    gt_rx_ctrl = c;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_word(32'd0, 4'd0);
  endtask

  task automatic send_body(input logic [31:0] seq, input logic [15:0] len,
                           input logic [7:0] typ, input logic [31:0] chk);
    drive_word(seq, 4'd0);
    drive_word({len, 8'h00, typ}, 4'd0);
    if (len >= 16'd1 && len <= 16'd1024) begin
      for (int i = 0; i < int'(len); i++) drive_word(32'(i + 1), 4'd0);
      drive_word(chk, 4'd0);
    end
  endtask

  task automatic send_frame(input logic [31:0] seq, input logic [15:0] len,
                            input logic [7:0] typ, input logic [31:0] chk);
    drive_word(32'h0000_00BC, 4'h1);
    send_body(seq, len, typ, chk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    drive_word(32'd0, 4'd0);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge rx_clk);
    #1;
    check_eq("rst_packet_cnt", packet_cnt_o, 64'd0);
    check_eq("rst_pkt_done", pkt_done, 64'd0);
    check_eq("rst_pkt_ok", pkt_ok, 64'd0);
    check_eq("rst_pkt_len", pkt_len_o, 64'd0);
    check_eq("rst_seq_locked", seq_locked_o, 64'd0);
    rst = 1'b0;
    idle(2);

    // Three good frames
    send_frame(32'd5, 16'd4, 8'h11, 32'd10);
    check_eq("good1_done", pkt_done, 64'd1);
    check_eq("good1_ok", pkt_ok, 64'd1);
    send_frame(32'd6, 16'd4, 8'h11, 32'd10);
    send_frame(32'd7, 16'd4, 8'h22, 32'd10);
    check_eq("good3_type", pkt_type_o, 64'h22);
    check_eq("good3_len", pkt_len_o, 64'd4);
    idle(1);
    check_eq("good_done_single", pkt_done, 64'd0);
    check_eq("good_packet_cnt", packet_cnt_o, 64'd3);
    check_eq("good_err_cnt", err_cnt_o, 64'd0);
    check_eq("good_done_pulses", done_cnt, 64'd3);
    check_eq("good_ok_pulses", ok_cnt, 64'd3);
    check_eq("good_seq_locked", seq_locked_o, 64'(SEQ_EN));

    // Checksum error
    send_frame(32'd8, 16'd4, 8'h11, 32'd11);
    check_eq("csum_ok", pkt_ok, 64'd0);
    check_eq("csum_err_cnt", csum_err_cnt_o, 64'd1);
    check_eq("csum_err_total", err_cnt_o, 64'd1);
    check_eq("csum_packet_cnt", packet_cnt_o, 64'd4);

    // Sequence wrap and discontinuity
    pulse_clr();
    check_eq("clr_packet_cnt", packet_cnt_o, 64'd0);
    check_eq("clr_csum_cnt", csum_err_cnt_o, 64'd0);
    check_eq("clr_seq_locked", seq_locked_o, 64'd0);
    send_frame(32'hFFFF_FFFF, 16'd4, 8'h01, 32'd10);
    send_frame(32'h0000_0000, 16'd4, 8'h01, 32'd10);
    check_eq("seq_wrap_ok", pkt_ok, 64'd1);
    check_eq("seq_wrap_err", seq_err_cnt_o, 64'd0);
    send_frame(32'd2, 16'd4, 8'h01, 32'd10);
    check_eq("seq_gap_ok", pkt_ok, 64'(!SEQ_EN));
    check_eq("seq_gap_err", seq_err_cnt_o, 64'(SEQ_EN));
    send_frame(32'd3, 16'd4, 8'h01, 32'd10);
    check_eq("seq_resync_ok", pkt_ok, 64'd1);
    check_eq("seq_resync_err", seq_err_cnt_o, 64'(SEQ_EN));
    check_eq("seq_err_total", err_cnt_o, 64'(SEQ_EN));

    // Length errors and the MAX_LEN boundary
    pulse_clr();
    send_frame(32'd4, 16'd0, 8'h05, 32'd0);
    check_eq("len0_done", pkt_done, 64'd1);
    check_eq("len0_ok", pkt_ok, 64'd0);
    send_frame(32'd5, 16'd2000, 8'h06, 32'd0);
    check_eq("len2000_len", pkt_len_o, 64'd2000);
    check_eq("len2000_type", pkt_type_o, 64'h06);
    check_eq("len_err_cnt2", len_err_cnt_o, 64'd2);
    check_eq("len_packet_cnt2", packet_cnt_o, 64'd2);
    send_frame(32'd6, 16'd1025, 8'h07, 32'd0);
    check_eq("len1025_err", len_err_cnt_o, 64'd3);
    send_frame(32'd7, 16'd1024, 8'h08, 32'h0008_0200);
    check_eq("len1024_ok", pkt_ok, 64'd1);
    send_frame(32'd8, 16'd4, 8'h09, 32'd10);
    check_eq("len_after_ok", pkt_ok, 64'd1);
    check_eq("len_packet_cnt", packet_cnt_o, 64'd5);
    check_eq("len_err_total", err_cnt_o, 64'd3);
    check_eq("len_seq_err", seq_err_cnt_o, 64'd0);

    // Truncation by a header inside the payload
    pulse_clr();
    drive_word(32'h0000_00BC, 4'h1);
    drive_word(32'd9, 4'd0);
    drive_word({16'd8, 8'h00, 8'h33}, 4'd0);
    drive_word(32'd1, 4'd0);
    drive_word(32'd2, 4'd0);
    drive_word(32'h1234_56BC, 4'h1);
    check_eq("trunc_done", pkt_done, 64'd1);
    check_eq("trunc_ok", pkt_ok, 64'd0);
    check_eq("trunc_len", pkt_len_o, 64'd8);
    send_body(32'd10, 16'd4, 8'h44, 32'd10);
    check_eq("trunc_next_ok", pkt_ok, 64'd1);
    check_eq("trunc_next_type", pkt_type_o, 64'h44);
    check_eq("trunc_err_cnt", trunc_err_cnt_o, 64'd1);
    check_eq("trunc_packet_cnt", packet_cnt_o, 64'd2);
    check_eq("trunc_err_total", err_cnt_o, 64'd1);
    check_eq("trunc_seq_err", seq_err_cnt_o, 64'd0);

    // clr together with the terminating word
    drive_word(32'h0000_00BC, 4'h1);
    drive_word(32'd11, 4'd0);
    drive_word({16'd1, 8'h00, 8'h55}, 4'd0);
    drive_word(32'd7, 4'd0);
    clr = 1'b1;
    drive_word(32'd7, 4'd0);
    clr = 1'b0;
    check_eq("clrdone_done", pkt_done, 64'd1);
    check_eq("clrdone_ok", pkt_ok, 64'd1);
    check_eq("clrdone_packet_cnt", packet_cnt_o, 64'd0);
    check_eq("clrdone_trunc_cnt", trunc_err_cnt_o, 64'd0);
    check_eq("clrdone_seq_locked", seq_locked_o, 64'd0);

    // Reset in the middle of the payload
    send_frame(32'd12, 16'd4, 8'h66, 32'd10);
    check_eq("pre_rst_packet_cnt", packet_cnt_o, 64'd1);
    drive_word(32'h0000_00BC, 4'h1);
    drive_word(32'd13, 4'd0);
    drive_word({16'd4, 8'h00, 8'h77}, 4'd0);
    drive_word(32'd1, 4'd0);
    drive_word(32'd2, 4'd0);
    rst = 1'b1;
    #2;
    check_eq("midrst_packet_cnt", packet_cnt_o, 64'd0);
    check_eq("midrst_seq_locked", seq_locked_o, 64'd0);
    check_eq("midrst_pkt_len", pkt_len_o, 64'd0);
    @(posedge rx_clk);
    #1;
    rst = 1'b0;
    begin
      int done_before;
      done_before = done_cnt;
      drive_word(32'd3, 4'd0);
      drive_word(32'd4, 4'd0);
      drive_word(32'd10, 4'd0);
      idle(8);
      check_eq("midrst_no_done", done_cnt, 64'(done_before));
    end
    check_eq("midrst_packet_cnt_after", packet_cnt_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_chk.md
PACKET_CHK -- requirements
Module: packet_chk

Interface
REQ-001 The block SHALL have parameter K_CHAR, default 8'hBC, the header K-character matched on gt_rx_data[7:0].
REQ-002 The block SHALL have parameter MAX_LEN, default 16'd1024, the largest legal payload length in 32-bit words.
REQ-003 The block SHALL have parameter CNT_W, default 32, the width of every statistics counter.
REQ-004 The block SHALL have ports, one per line:
  rx_clk  in  1  receive clock; all logic on rising edge.
  rst  in  1  asynchronous, active-high reset.
  clr  in  1  synchronous counter/sequence clear, one-cycle pulse.
  gt_rx_data  in  32  GT receive word, one valid word every cycle.
  gt_rx_ctrl  in  4  per-byte K flags; bit 0 qualifies the header.
  pkt_done  out  1  one-cycle pulse per terminated packet.
  pkt_ok  out  1  qualifies pkt_done; 1 = no error.
  pkt_type_o  out  8  type of last terminated packet.
  pkt_len_o  out  16  declared length of last terminated packet.
  packet_cnt_o  out  CNT_W  terminated packets.
  err_cnt_o  out  CNT_W  packets with at least one error.
  csum_err_cnt_o  out  CNT_W  checksum mismatches.
  seq_err_cnt_o  out  CNT_W  sequence discontinuities.
  len_err_cnt_o  out  CNT_W  length 0 or above MAX_LEN.
  trunc_err_cnt_o  out  CNT_W  header seen inside payload or check word.
  seq_locked_o  out  1  a reference sequence number is held.

Function
REQ-005 Frame format SHALL be: header word (gt_rx_ctrl[0]=1, data[7:0]=K_CHAR), sequence word, control word (len=[31:16], type=[7:0]), len payload words, check word = 32-bit wrap-around sum of the payload words.
REQ-006 FSM states SHALL be IDLE, WAIT_HEADER, SEQ_NUM, CTRL, DATA, CHECK; IDLE->WAIT_HEADER unconditionally; unused encodings ->IDLE.
REQ-007 WAIT_HEADER SHALL clear the checksum and move to SEQ_NUM on a header word.
REQ-008 SEQ_NUM SHALL capture the sequence word and move to CTRL.
REQ-009 CTRL SHALL capture len/type and go to DATA if 1<=len<=MAX_LEN; otherwise a length error terminates the packet and the FSM returns to WAIT_HEADER.
REQ-010 DATA SHALL accumulate every word into the checksum and go to CHECK after the len-th word.
REQ-011 A header word in DATA or CHECK SHALL terminate the current packet with a truncation error and go directly to SEQ_NUM (the header is reused, not lost).
REQ-012 CHECK SHALL compare gt_rx_data with the checksum, terminate the packet, and return to WAIT_HEADER.
REQ-013 Termination SHALL drive pkt_done=1 for exactly one cycle, on the cycle after the terminating word, with pkt_ok, pkt_type_o and pkt_len_o valid and held until the next termination.
REQ-014 Per termination, packet_cnt_o SHALL increment by 1, and err_cnt_o by 1 if any error occurred; each category counter SHALL increment by 1 if its error occurred.
REQ-015 All counters SHALL saturate at all-ones.
REQ-016 Sequence check: when unlocked, the first sequence word SHALL be accepted without error and SHALL set seq_locked_o; when locked, a value other than previous+1 (mod 2^32; FFFFFFFF->00000000 is legal) SHALL be a sequence error, and the received value SHALL become the new reference.
REQ-017 Length-error packets SHALL still update the sequence reference.
REQ-018 clr SHALL zero all counters and clear seq_locked_o; clr takes priority over a simultaneous increment; clr SHALL NOT disturb the FSM.

Reset
REQ-019 rst SHALL put the FSM in IDLE and set all counters, pkt_done, pkt_ok, pkt_type_o, pkt_len_o and seq_locked_o to 0, the checksum and sequence reference to 0, and the length counter to 0.
REQ-020 Reset during a packet SHALL discard it, with no pkt_done and no counter update.

Configuration
REQ-021 With PKT_CHK_SEQ_EN defined, sequence checking SHALL operate per REQ-016.
REQ-022 Without PKT_CHK_SEQ_EN, there SHALL be no sequence logic: seq_err_cnt_o and seq_locked_o are held at 0, and sequence words never cause an error.

Verification
REQ-023 Three good frames, seq 5,6,7, len 4, payload 1,2,3,4, check 10 -> packet_cnt 3, err_cnt 0, three pkt_ok pulses, seq_locked 1.
REQ-024 Frame with check 11 instead of 10 -> csum_err 1, err_cnt 1, pkt_ok 0.
REQ-025 Seq FFFFFFFF then 0, then 2 -> first pair clean, third gives seq_err 1, next seq 3 clean (without macro: seq_err stays 0).
REQ-026 len=0 frame, then len=2000 frame -> len_err 2, packet_cnt 2; a following good frame is accepted.
REQ-027 Header injected at payload word 2 of a len-8 frame, followed by a good frame -> trunc_err 1, the good frame is counted ok, and the total is 2 packets.
REQ-028 clr coincident with a pkt_done, and rst mid-DATA -> counters read 0 and seq_locked 0; after rst, no spurious pkt_done.
